// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: fetch FSM states,
// opcode field position, default widths and offset-field widths.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;

    localparam logic [15:0] RESET_PC = 16'h0000;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    // Offset fields carried in the instruction word, sign-extended downstream.
    localparam int OFFS11_W = 11;
    localparam int OFFS8_W  = 8;
    localparam int OFFS5_W  = 5;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/flag_reg.sv
// Status flag register {C,V,S,Z} with write enable and async active-low reset.
module flag_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (we) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, instruction register, req/ack fetch FSM and
// status flags feeding the CPU controller.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                INSTR_W      = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC_VAL = ADDR_W'(RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               exec_done,
    input  logic               ldPC2,
    input  logic               ldPCz,
    input  logic [ADDR_W-1:0]  pc_z,
    input  logic               flags_we,
    input  logic               c_in,
    input  logic               v_in,
    input  logic               s_in,
    input  logic               z_in,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic [OPC_W-1:0]   opcode,
    output logic               ir_valid,
    output logic               C,
    output logic               V,
    output logic               S,
    output logic               Z_det
);

    fetch_state_t       state_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic [INSTR_W-1:0] ir_reg;
    logic               req_reg;
    logic [3:0]         flags_q;

    // imem_req is a register reset to 0, so the first request appears one
    // cycle after reset release; an ack seen while req is low is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC_VAL;
            ir_reg    <= '0;
            req_reg   <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (req_reg && imem_ack) begin
                        ir_reg    <= imem_rdata;
                        state_reg <= EXEC;
                        req_reg   <= 1'b0;
                    end else begin
                        req_reg   <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        if (ldPCz) begin
                            pc_reg <= {pc_z[ADDR_W-1:1], 1'b0};
                        end else if (ldPC2) begin
                            pc_reg <= pc_reg + ADDR_W'(2);
                        end
                        state_reg <= FETCH;
                        req_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= FETCH;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    flag_reg #(
        .W(4)
    ) u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (flags_we),
        .d     ({c_in, v_in, s_in, z_in}),
        .q     (flags_q)
    );

    assign imem_req  = req_reg;
    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign ir        = ir_reg;
    assign opcode    = ir_reg[INSTR_W-1 -: OPC_W];
    assign ir_valid  = (state_reg == EXEC);
    assign C         = flags_q[3];
    assign V         = flags_q[2];
    assign S         = flags_q[1];
    assign Z_det     = flags_q[0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        exec_done;
    logic        ldPC2;
    logic        ldPCz;
    logic [15:0] pc_z;
    logic        flags_we;
    logic        c_in, v_in, s_in, z_in;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic        ir_valid;
    logic        C, V, S, Z_det;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .exec_done  (exec_done),
        .ldPC2      (ldPC2),
        .ldPCz      (ldPCz),
        .pc_z       (pc_z),
        .flags_we   (flags_we),
        .c_in       (c_in),
        .v_in       (v_in),
        .s_in       (s_in),
        .z_in       (z_in),
        .pc         (pc),
        .ir         (ir),
        .opcode     (opcode),
        .ir_valid   (ir_valid),
        .C          (C),
        .V          (V),
        .S          (S),
        .Z_det      (Z_det)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled and inputs driven at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
        exec_done = 1'b0; ldPC2 = 1'b0; ldPCz = 1'b0; pc_z = 16'h0000;
        flags_we = 1'b0; c_in = 1'b0; v_in = 1'b0; s_in = 1'b0; z_in = 1'b0;

        step();
        step();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_flags", {C, V, S, Z_det}, 4'b0000);

        // Back-to-back ALU instructions, ack tied high
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h0800; exec_done = 1'b1; ldPC2 = 1'b1;
        step();
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 16'h0000);
        chk("first_ir_valid", ir_valid, 1'b0);
        step();
        chk("exec0_valid", ir_valid, 1'b1);
        chk("exec0_req", imem_req, 1'b0);
        chk("exec0_ir", ir, 16'h0800);
        chk("exec0_opcode", opcode, 5'b00001);
        step();
        chk("fetch1_req", imem_req, 1'b1);
        chk("fetch1_addr", imem_addr, 16'h0002);
        step();
        chk("exec1_valid", ir_valid, 1'b1);
        step();
        chk("fetch2_addr", imem_addr, 16'h0004);
        chk("fetch2_req", imem_req, 1'b1);

        // Delayed ack: request holds for 3 stalled cycles
        imem_ack = 1'b0; imem_rdata = 16'h8005; exec_done = 1'b0; ldPC2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req", imem_req, 1'b1);
            chk("stall_addr", imem_addr, 16'h0004);
            chk("stall_ir_valid", ir_valid, 1'b0);
        end
        imem_ack = 1'b1;
        step();
        chk("late_ir", ir, 16'h8005);
        chk("late_opcode", opcode, 5'b10000);
        chk("late_valid", ir_valid, 1'b1);

        // Stray ack during EXEC must not disturb ir
        imem_rdata = 16'h1234;
        step();
        chk("stray_ir", ir, 16'h8005);
        chk("stray_valid", ir_valid, 1'b1);
        chk("stray_req", imem_req, 1'b0);

        // Jump: ldPCz beats ldPC2 and bit 0 is cleared
        ldPCz = 1'b1; ldPC2 = 1'b1; pc_z = 16'h1235; exec_done = 1'b1;
        step();
        chk("jump_addr", imem_addr, 16'h1234);
        chk("jump_req", imem_req, 1'b1);

        // Jump to FFFE, then wrap with ldPC2
        imem_rdata = 16'h0800; exec_done = 1'b0; ldPC2 = 1'b0; ldPCz = 1'b0;
        step();
        chk("pre_wrap_valid", ir_valid, 1'b1);
        ldPCz = 1'b1; pc_z = 16'hFFFF; exec_done = 1'b1;
        step();
        chk("at_fffe_addr", imem_addr, 16'hFFFE);
        ldPCz = 1'b0; ldPC2 = 1'b1;
        step();
        chk("wrap_exec_valid", ir_valid, 1'b1);
        chk("wrap_exec_pc", pc, 16'hFFFE);
        step();
        chk("wrap_addr", imem_addr, 16'h0000);

        // exec_done with no PC load holds the PC
        ldPC2 = 1'b0;
        step();
        step();
        chk("hold_addr", imem_addr, 16'h0000);
        chk("hold_req", imem_req, 1'b1);

        // Flags written during FETCH
        imem_ack = 1'b0; flags_we = 1'b1; c_in = 1'b1; v_in = 1'b0; s_in = 1'b1; z_in = 1'b1;
        step();
        chk("flags_set", {C, V, S, Z_det}, 4'b1011);
        flags_we = 1'b0; c_in = 1'b0; s_in = 1'b0; z_in = 1'b0;
        step();
        chk("flags_hold", {C, V, S, Z_det}, 4'b1011);

        // Move to pc=0040 in EXEC, then reset mid-EXEC
        imem_ack = 1'b1; exec_done = 1'b0;
        step();
        ldPCz = 1'b1; pc_z = 16'h0040; exec_done = 1'b1;
        step();
        ldPCz = 1'b0; exec_done = 1'b0;
        step();
        chk("pre_rst_pc", pc, 16'h0040);
        chk("pre_rst_valid", ir_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_pc", pc, 16'h0000);
        chk("async_ir", ir, 16'h0000);
        chk("async_flags", {C, V, S, Z_det}, 4'b0000);
        chk("async_valid", ir_valid, 1'b0);
        chk("async_req", imem_req, 1'b0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();
        chk("rerel_req", imem_req, 1'b1);
        chk("rerel_addr", imem_addr, 16'h0000);
        chk("rerel_valid", ir_valid, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
